// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a/b over 00..11, checks 8 gate outputs against golden OR/AND/XOR/NOT, reports stats via start/done
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           y,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           fail_vec,
  output logic [1:0]           first_fail_ab,
  output logic                 first_fail_valid
);
  localparam int SC = SETTLE_CYCLES < 1 ? 1 : SETTLE_CYCLES;
  localparam int CW = $clog2(SC) + 1;
  localparam logic [ERR_CNT_W+3:0] MAX = {4'b0, {ERR_CNT_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, ffab_q, ffab_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [7:0] fv_q, fv_d, mm;
  logic ffv_q, ffv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0] g;
  logic [ERR_CNT_W+3:0] sum;
  always_comb begin
    g = {~idx_q[1], ^idx_q, &idx_q, |idx_q};
    mm = y ^ {g, g};
    sum = {4'b0, err_q} + (ERR_CNT_W+4)'($countones(mm));
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    fv_d = fv_q;
    ffab_d = ffab_q;
    ffv_d = ffv_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        idx_d = '0;
        cnt_d = '0;
        err_d = '0;
        fv_d = '0;
        ffab_d = '0;
        ffv_d = 1'b0;
      end
      SETTLE: begin
        state_d = cnt_q == CW'(SC - 1) ? CHECK : SETTLE;
        cnt_d = cnt_q == CW'(SC - 1) ? cnt_q : cnt_q + CW'(1);
      end
      CHECK: begin
        fv_d = fv_q | mm;
        err_d = sum > MAX ? MAX[ERR_CNT_W-1:0] : sum[ERR_CNT_W-1:0];
        ffab_d = (|mm && !ffv_q) ? idx_q : ffab_q;
        ffv_d = ffv_q | (|mm);
        idx_d = idx_q + 2'd1;
        cnt_d = '0;
        state_d = idx_q == 2'd3 ? DONE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == SETTLE || state_d == CHECK;
    done_d = state_d == DONE;
    pass_d = done_d && err_d == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      fv_q <= '0;
      ffab_q <= '0;
      ffv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fv_q <= fv_d;
      ffab_q <= ffab_d;
      ffv_q <= ffv_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign a = idx_q[1];
  assign b = idx_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign fail_vec = fv_q;
  assign first_fail_ab = ffab_q;
  assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: randomized and directed sweeps of two checker configurations against a vector-level model
module tb_gate_sweep_checker;
  logic clk = 0, rst = 1;
  logic start [2];
  logic [7:0] y [2];
  logic a [2], b [2], busy [2], done [2], pass [2], ffv [2];
  logic [7:0] fv [2];
  logic [1:0] ffab [2];
  logic [5:0] e0;
  logic [3:0] e1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  gate_sweep_checker u0 (
    .clk(clk), .rst(rst), .start(start[0]), .y(y[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(e0),
    .fail_vec(fv[0]), .first_fail_ab(ffab[0]), .first_fail_valid(ffv[0])
  );
  gate_sweep_checker #(.SETTLE_CYCLES(3), .ERR_CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .y(y[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(e1),
    .fail_vec(fv[1]), .first_fail_ab(ffab[1]), .first_fail_valid(ffv[1])
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] gold(input int v);
    logic ga, gb;
    ga = v[1];
    gb = v[0];
    return {2{~ga, ga ^ gb, ga & gb, ga | gb}};
  endfunction
  function automatic int errc(input int d);
    return d ? int'(e1) : int'(e0);
  endfunction
  task automatic chk_zero(input int d);
    chk("rst_ab", {a[d], b[d]}, 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_done", done[d], 0);
    chk("rst_pass", pass[d], 0);
    chk("rst_err", errc(d), 0);
    chk("rst_fv", fv[d], 0);
    chk("rst_ffab", ffab[d], 0);
    chk("rst_ffv", ffv[d], 0);
  endtask
  task automatic sweep(input int d, input logic [7:0] am, input logic [7:0] om, input logic [7:0] xm, input bit poke);
    int sc, n, eerr, emax;
    logic [7:0] mm, efv;
    logic [1:0] effab;
    bit effv;
    sc = d ? 3 : 1;
    emax = d ? 15 : 63;
    n = 4 * (sc + 1);
    eerr = 0; efv = 0; effv = 0; effab = 0;
    for (int v = 0; v < 4; v++) begin
      mm = (((gold(v) & am) | om) ^ xm) ^ gold(v);
      eerr += $countones(mm);
      efv |= mm;
      if (mm != 0 && !effv) begin effv = 1; effab = 2'(v); end
    end
    if (eerr > emax) eerr = emax;
    @(negedge clk);
    start[d] = 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start[d] = poke && k == 3;
      chk("ab", {a[d], b[d]}, (k - 1) / (sc + 1));
      chk("busy", busy[d], 1);
      chk("done_early", done[d], 0);
      y[d] = (k % (sc + 1) == 0) ? (((gold((k - 1) / (sc + 1)) & am) | om) ^ xm) : 8'($urandom);
    end
    @(negedge clk);
    start[d] = 0;
    chk("done", done[d], 1);
    chk("busy_end", busy[d], 0);
    chk("ab_end", {a[d], b[d]}, 0);
    chk("pass", pass[d], eerr == 0);
    chk("err", errc(d), eerr);
    chk("fv", fv[d], efv);
    chk("ffab", ffab[d], effab);
    chk("ffv", ffv[d], effv);
  endtask
  task automatic reset_mid(input int d);
    int sc;
    sc = d ? 3 : 1;
    @(negedge clk);
    start[d] = 1;
    for (int k = 1; k <= 2 * (sc + 1) + 1; k++) begin
      @(negedge clk);
      start[d] = k == 2;
      y[d] = 8'($urandom);
    end
    chk("mid_ab", {a[d], b[d]}, 2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_zero(d);
    repeat (3) @(negedge clk);
    chk("idle_busy", busy[d], 0);
    chk("idle_done", done[d], 0);
  endtask
  initial begin
    start[0] = 0; start[1] = 0;
    y[0] = 8'($urandom); y[1] = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst = 0;
    sweep(0, 8'hFF, 8'h00, 8'h00, 0);
    sweep(0, 8'hFB, 8'h00, 8'h00, 0);
    sweep(0, 8'hFF, 8'h00, 8'h80, 0);
    sweep(0, 8'hFF, 8'h00, 8'h00, 0);
    sweep(0, 8'hFF, 8'h00, 8'hFF, 0);
    sweep(1, 8'hFF, 8'h00, 8'hFF, 0);
    sweep(1, 8'hFF, 8'h00, 8'h00, 1);
    reset_mid(0);
    sweep(0, 8'hFF, 8'h00, 8'h00, 1);
    reset_mid(1);
    sweep(1, 8'hFF, 8'h00, 8'h00, 0);
    for (int i = 0; i < 24; i++) begin
      logic [7:0] am, om, xm;
      am = 8'($urandom) | 8'($urandom);
      om = 8'($urandom) & 8'($urandom) & 8'($urandom);
      xm = 8'($urandom) & 8'($urandom);
      if (i % 4 == 0) begin am = 8'hFF; om = 0; xm = 0; end
      sweep(i % 2, am, om, xm, 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking stimulus/response stage that sits directly upstream and downstream of the two-input NOR/NAND gate-equivalence block.
- On `start`, it drives the gate block's `a`/`b` inputs through all four combinations. After a programmable settle time it samples the eight gate outputs and compares them against golden functions.
- It accumulates mismatch statistics and reports pass/fail through a `start`/`done` handshake.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before its outputs are sampled; legal range is 1 or more, and 0 is treated as 1.
- ERR_CNT_W, 6, width of the mismatch-bit counter; the default covers the worst case of 32 mismatching bits.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sweep; sampled only in IDLE or DONE.
- y  input  8  gate outputs, with y[0]=y1 … y[7]=y8.
- a  output  1  stimulus to the gate block; a = idx[1].
- b  output  1  stimulus to the gate block; b = idx[0].
- busy  output  1  high while in SETTLE or CHECK.
- done  output  1  high in DONE; a level, held until the next start or rst.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  ERR_CNT_W  total mismatching output bits this sweep; saturating.
- fail_vec  output  8  sticky OR of per-bit mismatches this sweep.
- first_fail_ab  output  2  {a,b} of the first vector that had any mismatch.
- first_fail_valid  output  1  high once first_fail_ab has been captured.

Behaviour:
- Reset, while rst is high at the edge:
  - state goes to IDLE and idx to 0.
  - a, b, busy, done, pass, err_count, fail_vec, first_fail_ab and first_fail_valid all go to 0.
  - rst takes priority over every other event, including mid-sweep; a sweep interrupted by reset is abandoned and not resumed.
- Golden functions:
  - y1 = a|b, y2 = a&b, y3 = a^b, y4 = ~a.
  - y5 = a|b, y6 = a&b, y7 = a^b, y8 = ~a.
- Vector order: idx runs 0,1,2,3, giving {a,b} = 00, 01, 10, 11. a and b are registered outputs taken directly from idx.
- FSM states are IDLE, SETTLE, CHECK and DONE.
- IDLE:
  - a = b = 0.
  - When start=1: clear err_count, fail_vec, first_fail_ab and first_fail_valid; set idx=0 and settle counter=0; go to SETTLE.
- SETTLE:
  - If settle counter < SETTLE_CYCLES-1, increment it and stay in SETTLE.
  - Otherwise go to CHECK.
  - start is ignored.
- CHECK (exactly one cycle per vector):
  - Compute mm = y XOR expected({a,b}).
  - Update fail_vec |= mm.
  - Update err_count += popcount(mm), saturating at 2^ERR_CNT_W − 1.
  - If mm ≠ 0 and first_fail_valid=0, capture first_fail_ab = {a,b} and set first_fail_valid=1.
  - If idx == 3: set idx=0 (so a=b=0) and go to DONE.
  - Otherwise: increment idx, clear the settle counter and go to SETTLE.
- DONE:
  - done=1 and pass is valid; statistics hold.
  - When start=1, behave exactly as the IDLE start case: clear statistics, drop done, begin a new sweep.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 4·(SETTLE_CYCLES+1) edges after the edge that sampled start; this is 8 at the default.
- busy and done are never high together. A start held continuously high restarts a new sweep immediately after each DONE cycle.
- y is assumed stable before each CHECK edge; it is sampled only in CHECK.

Test Plan:
1. Correct gate block, SETTLE_CYCLES=1, one-cycle start pulse -> busy high for 8 cycles; then done=1, pass=1, err_count=0, fail_vec=0x00, first_fail_valid=0.
2. y[2] (y3) stuck at 0 -> err_count=2, fail_vec=0x04, first_fail_ab=2'b01, first_fail_valid=1, pass=0.
3. y[7] (y8) inverted -> err_count=4, fail_vec=0x80, first_fail_ab=2'b00. A second sweep with a correct block -> counters clear, pass=1.
4. All eight outputs inverted with ERR_CNT_W=4 -> err_count saturates at 15, fail_vec=0xFF. With the default width, the same stimulus gives err_count=32.
5. SETTLE_CYCLES=3 -> the a/b sequence 00, 01, 10, 11 changes every 4 cycles, y is sampled only on the 4th cycle of each vector, and done rises 16 edges after start.
6. rst asserted during vector idx=2, plus a start pulse while busy -> the start while busy has no effect; on reset all outputs return to 0 next edge and the state is IDLE; a fresh start runs a full 8-cycle sweep.
